instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction-fetch stage of the pipelined CPU. Holds the program counter, drives the byte address of the combinational instruction ROM, and captures the returned 32-bit big-endian instruction word into the IF/ID pipeline register together with PC+4. Accepts stall, flush and redirect control from the hazard unit and the EX-stage branch/jump logic, and freezes on a halt word.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ROM_BYTES, 64: ROM size in bytes, used only by the bounds check.
- HALT_WORD, 32'hFC00_0000: instruction encoding that halts fetch.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- rom_addr  out  32  byte address to the ROM; combinational copy of the PC.
- rom_data  in  32  instruction word from the ROM; combinational in rom_addr, valid in the same cycle.
- stall  in  1  hold the PC and the IF/ID register.
- flush  in  1  replace the IF/ID contents with a bubble.
- redirect  in  1  taken branch or jump from EX.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- ifid_instr  out  32  registered instruction; 0 when the stage holds a bubble.
- ifid_pc4  out  32  registered PC+4 of ifid_instr; 0 when the stage holds a bubble.
- ifid_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch is in the HALT state.
- fault  out  1  sticky out-of-range fetch flag; tied to 0 unless the bounds check is compiled in.

## Operation
- States:
  - RUN: normal fetch.
  - HALT: PC frozen, bubbles issued.
  - FAULT: PC frozen, bubbles issued; exists only with the macro.
- Reset (asynchronous):
  - PC = RESET_PC; state = RUN.
  - ifid_instr = 0, ifid_pc4 = 0, ifid_valid = 0, halted = 0, fault = 0.
- Per-edge priority in RUN:
  1. redirect: PC ← {redirect_pc[31:2], 2'b00}; IF/ID ← bubble. Overrides stall and flush.
  2. stall: PC holds. IF/ID holds, or becomes a bubble if flush is also high.
  3. flush: PC ← PC+4; IF/ID ← bubble.
  4. Otherwise: PC ← PC+4; ifid_instr ← rom_data; ifid_pc4 ← PC+4; ifid_valid ← 1.
- Halt entry:
  - Happens when case 4 captures rom_data == HALT_WORD. The halt word itself enters IF/ID as valid.
  - On entry the state goes to HALT and the PC stays at the halt word's address; it does not advance.
  - A redirect, stall or flush in the same cycle prevents entry.
- In HALT:
  - Each edge writes a bubble to IF/ID, except when stall is high without flush, which holds IF/ID.
  - redirect returns the state to RUN and loads the target, because the halt word may have been fetched on the wrong path.
  - stall and flush have no other effect.
- PC arithmetic is 32-bit modulo: PC = 32'hFFFF_FFFC advances to 0.
- The PC is always word-aligned.

## Timing
- Fetch latency is 1 cycle: the instruction at PC appears on ifid_* after the next rising edge.
- First edge after reset release: ifid_instr = ROM[RESET_PC], ifid_pc4 = RESET_PC+4, ifid_valid = 1.
- Redirect sampled at edge N:
  - After edge N: bubble in IF/ID.
  - After edge N+1: target instruction in IF/ID.
  - Exactly one bubble is inserted.
- rom_addr updates combinationally with the PC; no additional register exists between the PC and the ROM.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - In RUN, if PC+3 ≥ ROM_BYTES (computed in 33 bits), rom_data is not captured.
  - IF/ID ← bubble; state → FAULT; fault ← 1.
  - FAULT is left only by reset. Redirect is ignored in FAULT.
- FETCH_BOUNDS_CHECK_EN undefined:
  - No range check; every address is passed to the ROM unchecked.
  - The FAULT state is absent and fault is constant 0.

## Test plan
- Release reset with ROM words 0x20010005, 0x20020007 at bytes 0 and 4 → IF/ID shows (0x20010005, pc4 = 4, valid = 1), then (0x20020007, 8, 1).
- stall high for 2 cycles at PC = 8 → rom_addr stays 8 and IF/ID holds for both cycles; after release, the word at byte 8 arrives with pc4 = 12.
- redirect = 1, redirect_pc = 0x0000_0013 together with stall = 1 → PC becomes 0x10, one bubble (valid = 0, instr = 0), then the word at 0x10 with pc4 = 0x14.
- Halt word at byte 12 → it enters IF/ID as valid; halted = 1; rom_addr stays 12; bubbles follow. A later redirect to 0 → halted = 0 and fetch resumes at 0.
- Reset asserted mid-run at PC = 0x20, with no clock edge → PC = 0 and all ifid_* outputs = 0 immediately.
- With FETCH_BOUNDS_CHECK_EN, ROM_BYTES = 64, sequential fetch reaching PC = 64 → fault = 1, bubble in IF/ID, PC frozen at 64, redirect ignored. Without the macro, the same stimulus gives fault = 0 and PC advances to 68.

Source files
------------

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module  : instr_fetch
// Brief   : PC register, ROM address drive and IF/ID pipeline register with
//           stall/flush/redirect handling and halt detection. Optional bounds
//           check enabled by FETCH_BOUNDS_CHECK_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 64,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic        out_of_range;
  logic        unused_redirect_lsbs;

  assign pc_plus4             = pc_q + 32'd4;
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef FETCH_BOUNDS_CHECK_EN
  logic fault_q, fault_d;

  // Widened to 33 bits so a PC near the top of the address space cannot wrap
  // back into range.
  assign out_of_range = ({1'b0, pc_q} + 33'd3) >= 33'(ROM_BYTES);
  assign fault        = fault_q;
`else
  logic unused_rom_bytes;

  assign unused_rom_bytes = (ROM_BYTES != 0);
  assign out_of_range     = 1'b0;
  assign fault            = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d = fault_q;
`endif

    unique case (state_q)
      S_RUN: begin
        if (redirect) begin
          pc_d    = redirect_target;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (stall) begin
          if (flush) begin
            instr_d = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
          end
        end else if (flush) begin
          pc_d    = pc_plus4;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (out_of_range) begin
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          state_d = S_FAULT;
`ifdef FETCH_BOUNDS_CHECK_EN
          fault_d = 1'b1;
`endif
        end else begin
          instr_d = rom_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          // The halt word stays addressed so rom_addr points at it while halted.
          if (rom_data == HALT_WORD) begin
            state_d = S_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      S_HALT: begin
        if (redirect) begin
          state_d = S_RUN;
          pc_d    = redirect_target;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end else if (!(stall && !flush)) begin
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end
      end

      S_FAULT: begin
        instr_d = 32'd0;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  assign rom_addr   = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;
  assign halted     = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// Module  : tb_instr_fetch
// Brief   : Directed self-checking bench for instr_fetch.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        fault;

  logic [31:0] rom [0:63];

  int checks;
  int errors;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .ROM_BYTES(64),
    .HALT_WORD(HALT_WORD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .stall      (stall),
    .flush      (flush),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid),
    .halted     (halted),
    .fault      (fault)
  );

  assign rom_data = rom[rom_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    for (int i = 0; i < 64; i++) rom[i] = {16'h1000, 16'(i * 4)};
    rom[0] = 32'h2001_0005;
    rom[1] = 32'h2002_0007;

    // Reset state
    tick();
    tick();
    check("rst_addr",  rom_addr,   32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4",   ifid_pc4,   32'h0);
    check("rst_valid", {31'd0, ifid_valid}, 32'h0);
    check("rst_halt",  {31'd0, halted},     32'h0);
    check("rst_fault", {31'd0, fault},      32'h0);
    rst = 1'b0;

    // Sequential fetch
    tick();
    check("seq0_instr", ifid_instr, 32'h2001_0005);
    check("seq0_pc4",   ifid_pc4,   32'h4);
    check("seq0_valid", {31'd0, ifid_valid}, 32'h1);
    tick();
    check("seq1_instr", ifid_instr, 32'h2002_0007);
    check("seq1_pc4",   ifid_pc4,   32'h8);
    check("seq1_addr",  rom_addr,   32'h8);

    // Stall two cycles
    stall = 1'b1;
    tick();
    check("stall1_addr",  rom_addr,   32'h8);
    check("stall1_instr", ifid_instr, 32'h2002_0007);
    tick();
    check("stall2_addr",  rom_addr,   32'h8);
    check("stall2_pc4",   ifid_pc4,   32'h8);
    stall = 1'b0;
    tick();
    check("unstall_instr", ifid_instr, 32'h1000_0008);
    check("unstall_pc4",   ifid_pc4,   32'hC);

    // Redirect with stall, unaligned target
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0013;
    stall       = 1'b1;
    tick();
    check("redir_addr",  rom_addr,   32'h10);
    check("redir_valid", {31'd0, ifid_valid}, 32'h0);
    check("redir_instr", ifid_instr, 32'h0);
    redirect = 1'b0;
    stall    = 1'b0;
    tick();
    check("redir_tgt_instr", ifid_instr, 32'h1000_0010);
    check("redir_tgt_pc4",   ifid_pc4,   32'h14);

    // Flush alone
    flush = 1'b1;
    tick();
    check("flush_valid", {31'd0, ifid_valid}, 32'h0);
    check("flush_addr",  rom_addr, 32'h18);
    flush = 1'b0;
    tick();
    check("postflush_instr", ifid_instr, 32'h1000_0018);
    check("postflush_pc4",   ifid_pc4,   32'h1C);

    // Halt word at byte 12
    rom[3]      = HALT_WORD;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_000C;
    tick();
    check("h_redir_addr", rom_addr, 32'hC);
    redirect = 1'b0;
    tick();
    check("halt_instr",  ifid_instr, HALT_WORD);
    check("halt_pc4",    ifid_pc4,   32'h10);
    check("halt_valid",  {31'd0, ifid_valid}, 32'h1);
    check("halt_flag",   {31'd0, halted},     32'h1);
    check("halt_addr",   rom_addr,   32'hC);
    tick();
    check("halt_bub_valid", {31'd0, ifid_valid}, 32'h0);
    check("halt_bub_instr", ifid_instr, 32'h0);
    check("halt_hold_addr", rom_addr,   32'hC);
    check("halt_still",     {31'd0, halted}, 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    check("unhalt_flag", {31'd0, halted}, 32'h0);
    check("unhalt_addr", rom_addr, 32'h0);
    check("unhalt_valid", {31'd0, ifid_valid}, 32'h0);
    redirect = 1'b0;
    tick();
    check("resume_instr", ifid_instr, 32'h2001_0005);
    check("resume_pc4",   ifid_pc4,   32'h4);
    rom[3] = 32'h1000_000C;

`ifndef FETCH_BOUNDS_CHECK_EN
    // PC wraps modulo 2^32
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    check("wrap_addr", rom_addr, 32'hFFFF_FFFC);
    redirect = 1'b0;
    tick();
    check("wrap_instr", ifid_instr, 32'h1000_00FC);
    check("wrap_pc4",   ifid_pc4,   32'h0);
    check("wrap_next",  rom_addr,   32'h0);
`endif

    // Asynchronous reset mid-run at PC = 0x20
    redirect    = 1'b1;
    redirect_pc = 32'h0000_001C;
    tick();
    redirect = 1'b0;
    tick();
    check("pre_rst_addr",  rom_addr,   32'h20);
    check("pre_rst_instr", ifid_instr, 32'h1000_001C);
    #2;
    rst = 1'b1;
    #1;
    check("arst_addr",  rom_addr,   32'h0);
    check("arst_instr", ifid_instr, 32'h0);
    check("arst_pc4",   ifid_pc4,   32'h0);
    check("arst_valid", {31'd0, ifid_valid}, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_instr", ifid_instr, 32'h2001_0005);

    // Sequential fetch up to the end of the ROM
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0038;
    tick();
    redirect = 1'b0;
    tick();
    check("b56_instr", ifid_instr, 32'h1000_0038);
    tick();
    check("b60_instr", ifid_instr, 32'h1000_003C);
    check("b60_addr",  rom_addr,   32'h40);
    tick();
`ifdef FETCH_BOUNDS_CHECK_EN
    check("oob_fault", {31'd0, fault},      32'h1);
    check("oob_valid", {31'd0, ifid_valid}, 32'h0);
    check("oob_instr", ifid_instr, 32'h0);
    check("oob_addr",  rom_addr,   32'h40);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    check("oob_redir_addr",  rom_addr, 32'h40);
    check("oob_redir_fault", {31'd0, fault}, 32'h1);
`else
    check("nob_fault", {31'd0, fault}, 32'h0);
    check("nob_instr", ifid_instr, 32'h1000_0040);
    check("nob_pc4",   ifid_pc4,   32'h44);
    check("nob_addr",  rom_addr,   32'h44);
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    check("nob_redir_addr", rom_addr, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
